// File: rtl/multicore_run_controller.sv
// -----------------------------------------------------------------------------
// multicore_run_controller
//
// Purpose:
//   Run controller for an array of processor cores. On a start request it
//   holds the cores in reset for RST_CYCLES cycles, then enables them and
//   counts run cycles. Each core is retired when its instruction-memory
//   address equals the halt address latched at start. When every core has
//   retired the controller reports done. If the watchdog window runs out
//   first, it reports timeout. Both flags stay set until the next start or rst.
//
// Optional feature (macro MEMWR_COUNT_EN):
//   Defined   : adds wr_count, which holds one saturating 16-bit MEMWR counter
//               per core.
//   Undefined : wr_count is absent and core_memwr is ignored.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        single-cycle run request (ignored while busy)
//   halt_addr    IMADDR value meaning "program finished", sampled at start
//   core_pc      packed IMADDR per core, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   core_memwr   per-core MEMWR strobe
//   core_rst     reset to all cores
//   core_en      per-core run enable
//   busy         high while resetting cores or running
//   done         all cores finished (sticky)
//   timeout      watchdog expired (sticky)
//   done_mask    sticky per-core finished flags
//   cycle_count  RUN cycles elapsed
//   wr_count     (MEMWR_COUNT_EN only) per-core MEMWR counts, packed like core_pc
// -----------------------------------------------------------------------------
module multicore_run_controller #(
   parameter int unsigned NUM_CORES      = 2,
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [ADDR_WIDTH-1:0]           halt_addr,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_pc,
   input  logic [NUM_CORES-1:0]            core_memwr,
   output logic                            core_rst,
   output logic [NUM_CORES-1:0]            core_en,
   output logic                            busy,
   output logic                            done,
   output logic                            timeout,
   output logic [NUM_CORES-1:0]            done_mask,
   output logic [CNT_WIDTH-1:0]            cycle_count
`ifdef MEMWR_COUNT_EN
   ,
   output logic [NUM_CORES*16-1:0]         wr_count
`endif
);

   // Reset-phase counter only needs to hold RST_CYCLES-1
   localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int unsigned WRW = 16;

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_RESET_CORES = 3'd1;
   localparam logic [2:0] S_RUN         = 3'd2;
   localparam logic [2:0] S_DONE        = 3'd3;
   localparam logic [2:0] S_TIMEOUT     = 3'd4;

   logic [2:0]            state, state_nxt;
   logic [RCW-1:0]        rst_cnt, rst_cnt_nxt;
   logic [ADDR_WIDTH-1:0] halt_q, halt_nxt;
   logic [CNT_WIDTH-1:0]  count_nxt;
   logic [NUM_CORES-1:0]  mask_nxt;
   logic                  done_nxt;
   logic                  timeout_nxt;
   logic                  core_rst_nxt;
   logic [NUM_CORES-1:0]  core_en_nxt;
   logic                  busy_nxt;
   logic [NUM_CORES-1:0]  hit;
   logic                  launch;

   // A start is honoured only when the controller is not busy
   assign launch = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_TIMEOUT));

   // Per-core halt detection. An already-retired core has core_en low and cannot re-hit.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         hit[i] = core_en[i] && (core_pc[i*ADDR_WIDTH +: ADDR_WIDTH] == halt_q);
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt   = state;
      rst_cnt_nxt = rst_cnt;
      halt_nxt    = halt_q;
      count_nxt   = cycle_count;
      mask_nxt    = done_mask;
      done_nxt    = done;
      timeout_nxt = timeout;

      case (state)
         S_IDLE, S_DONE, S_TIMEOUT: begin
            if (launch) begin
               state_nxt   = S_RESET_CORES;
               halt_nxt    = halt_addr;
               count_nxt   = '0;
               mask_nxt    = '0;
               done_nxt    = 1'b0;
               timeout_nxt = 1'b0;
               rst_cnt_nxt = RCW'(RST_CYCLES - 1);
            end
         end
         S_RESET_CORES: begin
            if (rst_cnt == '0) begin
               state_nxt = S_RUN;
            end else begin
               rst_cnt_nxt = rst_cnt - RCW'(1);
            end
         end
         S_RUN: begin
            count_nxt = cycle_count + CNT_WIDTH'(1);
            mask_nxt  = done_mask | hit;
            // All-done takes priority over a watchdog expiry on the same edge
            if (&mask_nxt) begin
               state_nxt = S_DONE;
               done_nxt  = 1'b1;
            end else if (cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               state_nxt   = S_TIMEOUT;
               timeout_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Control outputs are registered from the state being entered
      core_rst_nxt = (state_nxt == S_IDLE) || (state_nxt == S_RESET_CORES);
      busy_nxt     = (state_nxt == S_RESET_CORES) || (state_nxt == S_RUN);
      core_en_nxt  = (state_nxt == S_RUN) ? ~mask_nxt : '0;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rst_cnt     <= '0;
         halt_q      <= '0;
         cycle_count <= '0;
         done_mask   <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         core_rst    <= 1'b1;
         core_en     <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         rst_cnt     <= rst_cnt_nxt;
         halt_q      <= halt_nxt;
         cycle_count <= count_nxt;
         done_mask   <= mask_nxt;
         done        <= done_nxt;
         timeout     <= timeout_nxt;
         core_rst    <= core_rst_nxt;
         core_en     <= core_en_nxt;
         busy        <= busy_nxt;
      end
   end

`ifdef MEMWR_COUNT_EN
   logic [NUM_CORES*WRW-1:0] wr_nxt;

   // MEMWR counters count only enabled cores in RUN, saturate, and clear on launch
   always_comb begin
      wr_nxt = wr_count;
      if (launch) begin
         wr_nxt = '0;
      end else if (state == S_RUN) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (core_en[i] && core_memwr[i] && (wr_count[i*WRW +: WRW] != 16'hFFFF)) begin
               wr_nxt[i*WRW +: WRW] = wr_count[i*WRW +: WRW] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count <= '0;
      end else begin
         wr_count <= wr_nxt;
      end
   end
`else
   // MEMWR strobes have no consumer in this build
   logic unused_memwr;
   assign unused_memwr = ^{core_memwr, WRW[0]};
`endif

endmodule

// File: tb/tb_multicore_run_controller.sv
// -----------------------------------------------------------------------------
// tb_multicore_run_controller
//
// Self-checking bench for multicore_run_controller (NUM_CORES=2, RST_CYCLES=2,
// TIMEOUT_CYCLES=100). A run is described by the RUN cycle at which each core's
// PC equals the halt address. The expected per-cycle enables, the final flags,
// the final cycle count and the MEMWR counts are derived from those numbers.
// -----------------------------------------------------------------------------
module tb_multicore_run_controller;

   localparam int unsigned NC = 2;
   localparam int unsigned AW = 16;
   localparam int unsigned CW = 32;
   localparam int unsigned RC = 2;
   localparam int unsigned TO = 100;
   localparam int          NEVER = 100000;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [AW-1:0]    halt_addr;
   logic [NC*AW-1:0] core_pc;
   logic [NC-1:0]    core_memwr;
   logic             core_rst;
   logic [NC-1:0]    core_en;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [NC-1:0]    done_mask;
   logic [CW-1:0]    cycle_count;
`ifdef MEMWR_COUNT_EN
   logic [NC*16-1:0] wr_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multicore_run_controller #(
      .NUM_CORES(NC), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
      .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .halt_addr(halt_addr),
      .core_pc(core_pc), .core_memwr(core_memwr), .core_rst(core_rst),
      .core_en(core_en), .busy(busy), .done(done), .timeout(timeout),
      .done_mask(done_mask), .cycle_count(cycle_count)
`ifdef MEMWR_COUNT_EN
      , .wr_count(wr_count)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] not_h(input logic [AW-1:0] h);
      logic [AW-1:0] v;
      v = AW'($urandom);
      if (v == h) v = v ^ AW'(1);
      return v;
   endfunction

   // One complete run. f0/f1 are the RUN cycles at which each core hits halt.
   // A value >= TO means the core never hits halt within the window.
   task automatic run_scenario(input string name, input int f0, input int f1,
                               input logic [AW-1:0] h, input bit poke_start);
      int            f[NC];
      int            last;
      bit            all_done;
      int            exp_wr[NC];
      logic [NC-1:0] exp_en;
      logic [NC-1:0] exp_mask;
      logic [NC*AW-1:0] pcv;
      logic [3:0]    ctl;
      f[0] = f0; f[1] = f1;
      all_done = 1'b1; last = 0;
      for (int i = 0; i < NC; i++) begin
         exp_wr[i] = 0;
         if (f[i] > int'(TO) - 1) all_done = 1'b0;
         else if (f[i] > last) last = f[i];
      end
      if (!all_done) last = int'(TO) - 1;

      halt_addr = h; start = 1'b1;
      tick;
      start = 1'b0;
      halt_addr = not_h(h);  // must not affect the latched halt address

      // Core-reset phase. A halt PC here must be ignored.
      for (int k = 0; k < int'(RC); k++) begin
         core_pc = {NC{h}};
         core_memwr = NC'($urandom);
         n_tests++;
         ctl = {core_rst, busy, done, timeout};
         if (ctl !== 4'b1100 || core_en !== '0 || done_mask !== '0 || cycle_count !== '0) begin
            n_fail++;
            $display("FAIL %s reset_phase k=%0d ctl=%b en=%b mask=%b cnt=%0d exp ctl=1100 en=00 mask=00 cnt=0",
                     name, k, ctl, core_en, done_mask, cycle_count);
         end
`ifdef MEMWR_COUNT_EN
         n_tests++;
         if (wr_count !== '0) begin
            n_fail++;
            $display("FAIL %s wr_clear got %h exp 0", name, wr_count);
         end
`endif
         start = (poke_start && k == 0);
         tick;
         start = 1'b0;
      end

      // RUN phase
      for (int k = 0; k <= last; k++) begin
         for (int i = 0; i < NC; i++) begin
            pcv[i*AW +: AW] = (k == f[i] || (k > f[i] && $urandom_range(1) == 1)) ? h : not_h(h);
            core_memwr[i] = 1'($urandom_range(1));
            if (k <= f[i] && core_memwr[i]) exp_wr[i]++;
            exp_en[i]   = (k <= f[i]);
            exp_mask[i] = (k > f[i]);
         end
         core_pc = pcv;
         start = (poke_start && k == 3);
         n_tests++;
         ctl = {core_rst, busy, done, timeout};
         if (ctl !== 4'b0100 || core_en !== exp_en || done_mask !== exp_mask
             || cycle_count !== CW'(k)) begin
            n_fail++;
            $display("FAIL %s run k=%0d ctl=%b en=%b mask=%b cnt=%0d exp ctl=0100 en=%b mask=%b cnt=%0d",
                     name, k, ctl, core_en, done_mask, cycle_count, exp_en, exp_mask, k);
         end
         tick;
         start = 1'b0;
      end

      // Finished. Results must hold steady regardless of core activity.
      for (int i = 0; i < NC; i++) exp_mask[i] = (f[i] <= last);
      for (int j = 0; j < 3; j++) begin
         n_tests++;
         ctl = {core_rst, busy, done, timeout};
         if (ctl !== {2'b00, all_done, ~all_done} || core_en !== '0 || done_mask !== exp_mask
             || cycle_count !== CW'(last + 1)) begin
            n_fail++;
            $display("FAIL %s end j=%0d ctl=%b en=%b mask=%b cnt=%0d exp ctl=00%b%b en=00 mask=%b cnt=%0d",
                     name, j, ctl, core_en, done_mask, cycle_count, all_done, ~all_done,
                     exp_mask, last + 1);
         end
`ifdef MEMWR_COUNT_EN
         n_tests++;
         if (wr_count !== {16'(exp_wr[1]), 16'(exp_wr[0])}) begin
            n_fail++;
            $display("FAIL %s wr_count got %h exp %04h%04h", name, wr_count,
                     16'(exp_wr[1]), 16'(exp_wr[0]));
         end
`endif
         core_pc = {NC{h}};
         core_memwr = NC'($urandom);
         tick;
      end
   endtask

   task automatic test_reset;
      logic [3:0] ctl;
      rst = 1'b1; start = 1'b1;  // rst overrides start
      for (int k = 0; k < 3; k++) tick;
      n_tests++;
      ctl = {core_rst, busy, done, timeout};
      if (ctl !== 4'b1000 || core_en !== '0 || done_mask !== '0 || cycle_count !== '0) begin
         n_fail++;
         $display("FAIL reset ctl=%b en=%b mask=%b cnt=%0d exp ctl=1000 en=00 mask=00 cnt=0",
                  ctl, core_en, done_mask, cycle_count);
      end
      rst = 1'b0; start = 1'b0;
      tick; tick;
      n_tests++;
      ctl = {core_rst, busy, done, timeout};
      if (ctl !== 4'b1000 || core_en !== '0 || cycle_count !== '0) begin
         n_fail++;
         $display("FAIL idle ctl=%b en=%b cnt=%0d exp ctl=1000 en=00 cnt=0", ctl, core_en, cycle_count);
      end
   endtask

   task automatic test_normal_run;
      run_scenario("normal", 10, 25, 16'h0040, 1'b0);
   endtask

   task automatic test_timeout;
      run_scenario("timeout", 10, NEVER, 16'h0040, 1'b0);
   endtask

   task automatic test_tie;
      run_scenario("tie", int'(TO) - 1, int'(TO) - 1, 16'h1234, 1'b0);
   endtask

   task automatic test_start_while_busy;
      run_scenario("busy_start", 7, 4, 16'hBEEF, 1'b1);
   endtask

   task automatic test_back_to_back;
      run_scenario("b2b_a", 0, 0, 16'h0000, 1'b0);
      run_scenario("b2b_b", 3, NEVER, 16'hFFFF, 1'b0);
      run_scenario("b2b_c", 50, 2, 16'h00A5, 1'b0);
   endtask

   task automatic test_mid_run_reset;
      logic [3:0] ctl;
      logic [AW-1:0] h;
      h = 16'h0777;
      halt_addr = h; start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 0; k < int'(RC); k++) tick;
      for (int k = 0; k < 5; k++) begin
         core_pc = {not_h(h), (k == 2) ? h : not_h(h)};
         core_memwr = 2'b11;
         tick;
      end
      n_tests++;
      if (done_mask !== 2'b01 || cycle_count !== CW'(5) || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre mask=%b cnt=%0d busy=%b exp mask=01 cnt=5 busy=1",
                  done_mask, cycle_count, busy);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      n_tests++;
      ctl = {core_rst, busy, done, timeout};
      if (ctl !== 4'b1000 || core_en !== '0 || done_mask !== '0 || cycle_count !== '0) begin
         n_fail++;
         $display("FAIL midrst ctl=%b en=%b mask=%b cnt=%0d exp ctl=1000 en=00 mask=00 cnt=0",
                  ctl, core_en, done_mask, cycle_count);
      end
`ifdef MEMWR_COUNT_EN
      n_tests++;
      if (wr_count !== '0) begin
         n_fail++;
         $display("FAIL midrst_wr got %h exp 0", wr_count);
      end
`endif
      tick;
      n_tests++;
      if (busy !== 1'b0 || core_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_idle busy=%b core_rst=%b exp busy=0 core_rst=1", busy, core_rst);
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < 6; r++) begin
         run_scenario("random", $urandom_range(0, 130), $urandom_range(0, 130),
                      AW'($urandom), 1'($urandom_range(1)));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; halt_addr = '0; core_pc = '0; core_memwr = '0;
      test_reset;
      test_normal_run;
      test_timeout;
      test_tie;
      test_start_while_busy;
      test_back_to_back;
      test_mid_run_reset;
      test_random;
      test_normal_run;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
